dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the processor's 8-bit data memory. Shares the single memory port (`Rm`/`Wm`/`address`/write data/read data) between the CPU load/store unit and an I/O (DMA-style) requester. Each transaction uses a fixed three-cycle req/ack handshake, and read data is returned in a per-requester holding register. It sits between the execute stage / I/O block and the data memory. It is the only block allowed to drive the memory strobes.

## Interface
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low. Single clock domain.
- `cpu_req`  in  1  CPU request; level signal, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  last CPU read result, held.
- `io_req`, `io_we`, `io_addr`, `io_wdata`, `io_ack`, `io_rdata`: same as the CPU port, for the I/O requester.
- `mem_rm`  out  1  memory read strobe.
- `mem_wm`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; combinational, valid in the same cycle as `mem_rm`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
**States: IDLE → ACCESS → DONE → IDLE.**

**IDLE**
- If any request is high, pick a winner.
- Latch the winner's `we`, `addr` and `wdata` into internal registers, record the winner as `owner`, and go to ACCESS.
- If no request is high, stay in IDLE.

**ACCESS (exactly one cycle)**
- `mem_addr` and `mem_wdata` come from the latched registers.
- For a read: `mem_rm`=1, `mem_wm`=0, and `mem_rdata` is captured into the owner's `*_rdata` at the end of the cycle.
- For a write: `mem_wm`=1, `mem_rm`=0.
- Go to DONE.

**DONE (exactly one cycle)**
- `owner`'s `*_ack`=1.
- Go to IDLE.

**Strobes and outputs**
- `mem_rm` and `mem_wm` are never high together.
- Both strobes are 0 outside ACCESS.
- `mem_addr` and `mem_wdata` are 0 outside ACCESS.
- `*_rdata` changes only on a read by that requester. A write leaves it unchanged.

**Requester protocol**
- The requester keeps `req` and its fields stable until it samples `ack`=1.
- At that same edge it may drop `req` or present a new transaction (back-to-back is allowed).
- Because fields are latched on grant, a requester that drops `req` during ACCESS or DONE still completes and still receives `ack`.

**Arbitration**
- Applies when both requests are high in IDLE; see Configuration.
- A lone request is always granted.

**Reset**
- Reset applies at any time, including mid-transaction.
- State returns to IDLE. All outputs go to 0: `mem_*`, `*_ack`, `*_rdata`, `busy`.
- The in-flight transaction is abandoned with no ack. A write whose ACCESS cycle was cut short may or may not have landed.
- The round-robin pointer resets to "I/O last served", so the CPU wins the first tie.

## Timing
- Request first seen high at rising edge N (state IDLE): ACCESS runs N→N+1, DONE runs N+1→N+2, and `ack` is high in the cycle after edge N+1.
- Read data is valid on `*_rdata` in the same cycle as `ack` and stays until the next read for that requester.
- Throughput: one transaction per 3 cycles. Back-to-back requests by any mix of requesters have no idle bubble.
- `busy` is 1 in ACCESS and DONE.
- All outputs are registered or decoded from state only. There is no combinational path from `*_req` to any output.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin on ties.
  - The winner is the requester not served last.
  - A 1-bit `last` register updates on every grant.
  - Starvation is bounded to one transaction.
- `DMEM_ARB_RR_EN` undefined: fixed priority, CPU always wins ties.
  - No `last` register.
  - The I/O requester may starve under continuous CPU traffic.

## Test plan
- **Reset, then CPU write:** `cpu_we`=1, `cpu_addr`=0x03, `cpu_wdata`=0xA5 → in ACCESS, `mem_wm`=1, `mem_addr`=0x03, `mem_wdata`=0xA5; `cpu_ack` pulses one cycle later; `cpu_rdata` stays 0x00.
- **I/O read:** `io_addr`=0x03, memory returns 0xA5 → `mem_rm`=1 for one cycle; `io_ack` arrives 2 cycles after the request edge with `io_rdata`=0xA5; `cpu_rdata` is unchanged.
- **Simultaneous CPU and I/O requests held high for 4 transactions:**
  - With `DMEM_ARB_RR_EN`: grant order CPU, IO, CPU, IO, 12 cycles total.
  - Without it: CPU, CPU, CPU, CPU while `io_ack` stays 0.
- **CPU drops `cpu_req` during ACCESS:** the transaction still completes and `cpu_ack`=1; `mem_*` is not asserted again afterwards.
- **`rst_n` driven low asynchronously mid-ACCESS of a read:** `mem_rm`, `busy` and the acks go to 0 immediately; no ack follows release; the next request is served normally and the CPU wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the shared data memory port (CPU vs I/O).
// Optional round-robin tie-break enabled by defining DMEM_ARB_RR_EN; fixed CPU priority otherwise.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_rm,
    output logic              mem_wm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_io;
    logic              grant_io;

`ifdef DMEM_ARB_RR_EN
    // last_io = 1 means the I/O side was served last, so the CPU wins the next tie
    logic last_io;

    always_comb begin
        grant_io = io_req & (~cpu_req | ~last_io);
    end
`else
    always_comb begin
        grant_io = io_req & ~cpu_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            owner_io  <= 1'b0;
            cpu_rdata <= '0;
            io_rdata  <= '0;
`ifdef DMEM_ARB_RR_EN
            last_io   <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || io_req) begin
                        owner_io <= grant_io;
                        we_q     <= grant_io ? io_we    : cpu_we;
                        addr_q   <= grant_io ? io_addr  : cpu_addr;
                        wdata_q  <= grant_io ? io_wdata : cpu_wdata;
`ifdef DMEM_ARB_RR_EN
                        last_io  <= grant_io;
`endif
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (owner_io) io_rdata  <= mem_rdata;
                        else          cpu_rdata <= mem_rdata;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side and handshake outputs decode purely from state and latched fields
    always_comb begin
        mem_rm    = (state == ACCESS) & ~we_q;
        mem_wm    = (state == ACCESS) &  we_q;
        mem_addr  = (state == ACCESS) ? addr_q  : '0;
        mem_wdata = (state == ACCESS) ? wdata_q : '0;
        cpu_ack   = (state == DONE) & ~owner_io;
        io_ack    = (state == DONE) &  owner_io;
        busy      = (state != IDLE);
    end

endmodule
